// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared definitions for Gray-code counter and decoder blocks
package gray_pkg;

  // Decoder tracking state, encoded to match the register map view
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } gray_state_t;

  // Step direction; the counter's dir input uses the same encoding
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_updown_decoder.sv
// rtl/gray_updown_decoder.sv - Gray count receiver with direction inference and position accumulator
module gray_updown_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir_out,
  output logic             step,
  output logic             err,
  output logic             err_pulse,
  output logic [POS_W-1:0] pos
);

  localparam logic [WIDTH-1:0] DELTA_HOLD = '0;
  localparam logic [WIDTH-1:0] DELTA_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DOWN = '1;
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  gray_state_t      state;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;

  gray2bin #(
    .WIDTH(WIDTH)
  ) u_gray2bin (
    .gray(gray_in),
    .bin (dec)
  );

  // Modular difference against the last accepted value; wrap-around falls out naturally
  always_comb begin
    delta = dec - prev_bin;
  end

  // Tracking FSM: resync, classify each sampled step, accumulate position, latch errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SYNC;
      prev_bin  <= '0;
      bin_out   <= '0;
      dir_out   <= DIR_UP;
      step      <= 1'b0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      pos       <= '0;
    end else begin
      step      <= 1'b0;
      err_pulse <= 1'b0;
      if (clr_err) begin
        // A coincident sample is dropped; the next one resyncs
        err   <= 1'b0;
        state <= SYNC;
      end else if (sample) begin
        case (state)
          SYNC: begin
            prev_bin <= dec;
            bin_out  <= dec;
            state    <= TRACK;
          end
          TRACK: begin
            if (delta == DELTA_UP) begin
              prev_bin <= dec;
              bin_out  <= dec;
              dir_out  <= DIR_UP;
              pos      <= pos + POS_ONE;
              step     <= 1'b1;
            end else if (delta == DELTA_DOWN) begin
              prev_bin <= dec;
              bin_out  <= dec;
              dir_out  <= DIR_DOWN;
              pos      <= pos - POS_ONE;
              step     <= 1'b1;
            end else if (delta != DELTA_HOLD) begin
              // Missed steps: keep last good bin/pos/dir until software clears
              err       <= 1'b1;
              err_pulse <= 1'b1;
              state     <= ERROR;
            end
          end
          ERROR: begin
            state <= ERROR;
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_updown_decoder.sv
// tb/tb_gray_updown_decoder.sv - directed self-checking bench for gray_updown_decoder
module tb_gray_updown_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  gray_in;
  logic        sample;
  logic        clr_err;
  logic [3:0]  bin_out;
  logic        dir_out;
  logic        step;
  logic        err;
  logic        err_pulse;
  logic [15:0] pos;

  int checks;
  int errors;

  // Gray code for binary 0..15, written out by hand
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_updown_decoder #(
    .WIDTH(4),
    .POS_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .sample   (sample),
    .clr_err  (clr_err),
    .bin_out  (bin_out),
    .dir_out  (dir_out),
    .step     (step),
    .err      (err),
    .err_pulse(err_pulse),
    .pos      (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [3:0] g, input logic s, input logic c);
    @(negedge clk);
    gray_in = g;
    sample  = s;
    clr_err = c;
    @(posedge clk);
    #1;
    sample  = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; gray_in = 4'b0; sample = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bin_out !== 4'd0 || dir_out !== 1'b1 || step !== 1'b0 || err !== 1'b0 ||
        err_pulse !== 1'b0 || pos !== 16'd0) begin
      errors++;
      $display("FAIL reset: bin=%0d dir=%b step=%b err=%b ep=%b pos=%0d want 0 1 0 0 0 0",
               bin_out, dir_out, step, err, err_pulse, pos);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_up_sweep();
    int nstep;
    drive(gtab[0], 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd0 || step !== 1'b0 || pos !== 16'd0 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL up_sync: bin=%0d step=%b pos=%0d dir=%b want 0 0 0 1", bin_out, step, pos, dir_out);
    end
    nstep = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(gtab[i % 16], 1'b1, 1'b0);
      if (step === 1'b1) nstep++;
      checks++;
      if (bin_out !== 4'(i % 16) || dir_out !== 1'b1 || pos !== 16'(i)) begin
        errors++;
        $display("FAIL up_step%0d: bin=%0d dir=%b pos=%0d want %0d 1 %0d",
                 i, bin_out, dir_out, pos, i % 16, i);
      end
    end
    checks++;
    if (nstep != 16 || err !== 1'b0) begin
      errors++;
      $display("FAIL up_count: steps=%0d err=%b want 16 0", nstep, err);
    end
    idle();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL up_step_width: step=%b want 0", step);
    end
  endtask

  task automatic test_down_sweep();
    int nstep;
    nstep = 0;
    for (int i = 15; i >= 0; i--) begin
      drive(gtab[i], 1'b1, 1'b0);
      if (step === 1'b1) nstep++;
      checks++;
      if (bin_out !== 4'(i) || dir_out !== 1'b0 || pos !== 16'(i)) begin
        errors++;
        $display("FAIL down_bin%0d: bin=%0d dir=%b pos=%0d want %0d 0 %0d",
                 i, bin_out, dir_out, pos, i, i);
      end
    end
    checks++;
    if (nstep != 16 || err !== 1'b0) begin
      errors++;
      $display("FAIL down_count: steps=%0d err=%b want 16 0", nstep, err);
    end
  endtask

  task automatic test_hold_gaps();
    drive(gtab[0], 1'b1, 1'b0);
    checks++;
    if (step !== 1'b0 || bin_out !== 4'd0 || pos !== 16'd0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_same: step=%b bin=%0d pos=%0d dir=%b want 0 0 0 0", step, bin_out, pos, dir_out);
    end
    idle();
    idle();
    drive(gtab[1], 1'b1, 1'b0);
    checks++;
    if (step !== 1'b1 || bin_out !== 4'd1 || pos !== 16'd1 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL gap_up: step=%b bin=%0d pos=%0d dir=%b want 1 1 1 1", step, bin_out, pos, dir_out);
    end
    idle();
    checks++;
    if (step !== 1'b0 || pos !== 16'd1) begin
      errors++;
      $display("FAIL gap_idle: step=%b pos=%0d want 0 1", step, pos);
    end
    drive(gtab[3], 1'b0, 1'b0);
    checks++;
    if (step !== 1'b0 || bin_out !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL unsampled: step=%b bin=%0d err=%b want 0 1 0", step, bin_out, err);
    end
    drive(gtab[1], 1'b1, 1'b0);
    checks++;
    if (step !== 1'b0 || pos !== 16'd1) begin
      errors++;
      $display("FAIL hold_repeat: step=%b pos=%0d want 0 1", step, pos);
    end
    drive(gtab[0], 1'b1, 1'b0);
    checks++;
    if (step !== 1'b1 || bin_out !== 4'd0 || pos !== 16'd0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL gap_down: step=%b bin=%0d pos=%0d dir=%b want 1 0 0 0", step, bin_out, pos, dir_out);
    end
  endtask

  task automatic test_illegal();
    drive(4'b0011, 1'b1, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err !== 1'b1 || bin_out !== 4'd0 || pos !== 16'd0 ||
        step !== 1'b0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL illegal: ep=%b err=%b bin=%0d pos=%0d step=%b dir=%b want 1 1 0 0 0 0",
               err_pulse, err, bin_out, pos, step, dir_out);
    end
    idle();
    checks++;
    if (err_pulse !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: ep=%b err=%b want 0 1", err_pulse, err);
    end
    drive(gtab[1], 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd0 || step !== 1'b0 || pos !== 16'd0 || err !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_ignore: bin=%0d step=%b pos=%0d err=%b ep=%b want 0 0 0 1 0",
               bin_out, step, pos, err, err_pulse);
    end
  endtask

  task automatic test_recovery();
    drive(gtab[1], 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0 || bin_out !== 4'd0 || step !== 1'b0) begin
      errors++;
      $display("FAIL clr: err=%b bin=%0d step=%b want 0 0 0", err, bin_out, step);
    end
    drive(4'b0110, 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd4 || step !== 1'b0 || pos !== 16'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL resync: bin=%0d step=%b pos=%0d err=%b want 4 0 0 0", bin_out, step, pos, err);
    end
    drive(4'b0111, 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd5 || step !== 1'b1 || pos !== 16'd1 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL after_resync: bin=%0d step=%b pos=%0d dir=%b want 5 1 1 1", bin_out, step, pos, dir_out);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 6; i <= 11; i++) drive(gtab[i], 1'b1, 1'b0);
    checks++;
    if (pos !== 16'd7 || bin_out !== 4'd11) begin
      errors++;
      $display("FAIL pre_reset: pos=%0d bin=%0d want 7 11", pos, bin_out);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bin_out !== 4'd0 || dir_out !== 1'b1 || step !== 1'b0 || err !== 1'b0 ||
        err_pulse !== 1'b0 || pos !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: bin=%0d dir=%b step=%b err=%b ep=%b pos=%0d want 0 1 0 0 0 0",
               bin_out, dir_out, step, err, err_pulse, pos);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(gtab[9], 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd9 || step !== 1'b0 || pos !== 16'd0 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_sync: bin=%0d step=%b pos=%0d dir=%b want 9 0 0 1", bin_out, step, pos, dir_out);
    end
    drive(gtab[10], 1'b1, 1'b0);
    checks++;
    if (bin_out !== 4'd10 || step !== 1'b1 || pos !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_step: bin=%0d step=%b pos=%0d want 10 1 1", bin_out, step, pos);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_hold_gaps();
    test_illegal();
    test_recovery();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_updown_decoder.md
Name: gray_updown_decoder

Overview:
Receiver-side companion to the Gray-code up/down counter. Samples a Gray-coded count bus, decodes it to binary, infers the step direction from consecutive samples, and keeps a wide signed position accumulator across wrap-arounds. Flags illegal transitions (more than one step between samples) and holds in an error state until cleared. Sits downstream of the counter or any Gray-coded position source, in the same clock domain.

Parameters:
WIDTH, 4, Gray/binary count width.
POS_W, 16, width of the two's-complement position accumulator.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
gray_in  input  WIDTH  Gray-coded count being decoded
sample  input  1  qualifies gray_in this cycle
clr_err  input  1  clears sticky error and forces resync
bin_out  output  WIDTH  binary value of last accepted sample
dir_out  output  1  last step direction (1=up, 0=down)
step  output  1  one-cycle pulse per accepted ±1 step
err  output  1  sticky illegal-transition flag
err_pulse  output  1  one-cycle pulse on error detection
pos  output  POS_W  signed accumulated position

Behaviour:
- Reset (rst=0, asynchronous, any state): state=SYNC, bin_out=0, dir_out=1, step=0, err=0, err_pulse=0, pos=0, prev_bin=0.
- All outputs are registered. Response appears on the first rising edge where sample=1, and is visible the following cycle. step and err_pulse are high for exactly one cycle.
- dec = gray2bin(gray_in); delta = (dec - prev_bin) mod 2^WIDTH.
- SYNC: sample=1 -> prev_bin=bin_out=dec, go to TRACK. No step, pos unchanged, dir_out unchanged.
- TRACK, on sample=1:
  - delta=0: hold all outputs, no step.
  - delta=1: up. prev_bin=bin_out=dec, dir_out=1, pos+=1, step=1.
  - delta=2^WIDTH-1: down. prev_bin=bin_out=dec, dir_out=0, pos-=1, step=1.
  - any other delta: err=1, err_pulse=1, go to ERROR. bin_out, pos and dir_out hold their last good values.
- ERROR: sample ignored. Outputs hold. err stays 1.
- clr_err=1, any state: err=0, go to SYNC. clr_err takes priority over a coincident sample; that sample is discarded and the next sample resyncs. clr_err in SYNC or TRACK also forces SYNC.
- Wrap-around is legal:
  - bin 2^WIDTH-1 -> 0 is an up step.
  - 0 -> 2^WIDTH-1 is a down step.
  - pos wraps modulo 2^POS_W with no saturation.
- sample=0: no state change. step=0, err_pulse=0.
- States encoding: SYNC=0, TRACK=1, ERROR=2 (2-bit).

Decomposition:
- Shared package gray_pkg:
  - state enum/localparams SYNC, TRACK, ERROR.
  - DIR_UP=1, DIR_DOWN=0, also used by the counter's dir input.
- Sub-module gray2bin: combinational, parameter WIDTH, prefix-XOR from MSB. Reusable by other Gray consumers.
- The FSM, delta compare and accumulator live in the top module.

Test Plan:
- Up sweep: after reset, sample every cycle with gray 0000,0001,0011,0010,0110,…,1000,0000 (17 samples). First sample syncs bin_out=0. Then 16 step pulses, dir_out=1, bin_out 1..15 then 0, pos=16, err=0.
- Down sweep: continuing from that state, feed 1000,1001,…,0001,0000. bin_out 15 down to 0, dir_out=0, pos returns to 0, 16 step pulses.
- Hold/gaps: repeat the same gray value with sample=1, and toggle sample=0 between valid steps. No extra step pulses, pos counts only real transitions.
- Illegal jump: in TRACK at bin 0 (gray 0000), sample gray 0011 (bin 2). err_pulse for 1 cycle, err=1, bin_out=0 holds. Later samples are ignored.
- Recovery: assert clr_err together with sample=1. err=0, that sample is ignored. Next sample gray 0110 syncs bin_out=4, no step. Following 0111 gives bin_out=5, step=1, pos+1.
- Async reset mid-run: drop rst between clock edges while pos=7. All outputs go to reset values immediately. After release, first sample only resyncs.
